ring_osc_meter: RTL and testbench
=================================

RING_OSC_METER -- requirements
Module: ring_osc_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000: measurement window length in clk cycles; legal range 2..2^24-1.
REQ-002 Parameter CNT_W, default 16: width of the edge count result.
REQ-003 clk  input  1  single clock; all state is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 osc_in  input  1  oscillator output under test (e.g. ring-oscillator node); asynchronous to clk.
REQ-006 start  input  1  single-cycle request to begin a measurement.
REQ-007 busy  output  1  high while a measurement window is open.
REQ-008 valid  output  1  result available; held until acknowledged.
REQ-009 ack  input  1  consumer acknowledge of result.
REQ-010 count  output  CNT_W  number of osc_in rising edges counted in the window.
REQ-011 overflow  output  1  count saturated during the window.

Function
REQ-012 osc_in SHALL pass through a 2-flop synchronizer followed by a rising-edge detect register; a detected edge is one clk cycle wide and appears 3 clk cycles after the osc_in rise.
REQ-013 osc_in frequency SHALL be below clk/2 for correct counting; faster inputs are out of specification.
REQ-014 FSM states SHALL be IDLE, GATE and DONE.
REQ-015 IDLE: start=1 -> GATE on the next clock; gate timer and edge counter clear to 0 and overflow clears on that transition.
REQ-016 GATE: busy=1; the gate timer increments every cycle; each detected edge increments the edge counter.
REQ-017 GATE lasts exactly GATE_CYCLES cycles; an edge detected in the last GATE cycle SHALL be counted.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets overflow, which is sticky until the next start.
REQ-019 End of window -> DONE: count, overflow and valid=1 are registered together on the same clock; busy=0.
REQ-020 DONE: valid, count and overflow SHALL hold stable until ack=1; ack -> IDLE with valid=0 on the next clock.
REQ-021 start in GATE or DONE SHALL be ignored, including start and ack in the same DONE cycle; start must be reissued in IDLE.
REQ-022 ack outside DONE SHALL be ignored.
REQ-023 count and overflow SHALL keep their last result in IDLE until the next start clears them.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, busy=0, valid=0, count=0, overflow=0, clear all counters and clear the synchronizer flops to 0.
REQ-025 rst asserted mid-GATE or in DONE SHALL discard the measurement; after release no valid is produced until a new start.
REQ-026 On the first cycle after release, a high osc_in SHALL NOT produce a spurious edge until it has propagated through the synchronizer.

Configuration
REQ-027 Macro RING_OSC_METER_STUCK_DETECT_EN: when defined, output port stuck (1 bit) exists and is registered with valid: 1 if count<2, else 0; reset value 0; cleared on start.
REQ-028 Without RING_OSC_METER_STUCK_DETECT_EN, the stuck port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 GATE_CYCLES=1000, osc_in period 10 clk, start -> busy for 1000 cycles, then valid=1 with count 100 (+/-1), overflow=0.
REQ-030 osc_in held 0 -> count=0, overflow=0; with RING_OSC_METER_STUCK_DETECT_EN defined, stuck=1.
REQ-031 CNT_W=4, GATE_CYCLES=100, osc_in period 4 clk -> count=15, overflow=1; the next start clears overflow.
REQ-032 rst pulsed at window cycle 500 -> busy=0, valid=0, count=0 immediately; no valid appears without a new start.
REQ-033 start pulsed during GATE and during DONE -> ignored, no window restart; ack held low for 50 cycles keeps valid and count stable; ack=1 -> valid=0 on the next clock.

Source files
------------

// File: rtl/ring_osc_meter.sv
// Gated frequency meter: counts synchronized osc_in rising edges over GATE_CYCLES clk cycles.
// Optional stuck-oscillator flag enabled by defining RING_OSC_METER_STUCK_DETECT_EN.
module ring_osc_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
`ifdef RING_OSC_METER_STUCK_DETECT_EN
  output logic             stuck,
`endif
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TW = 24;
  localparam logic [TW-1:0]    LAST_TICK = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t          state, state_d;
  logic            sync1, sync2, sync_prev;
  logic            edge_det;
  logic [TW-1:0]   timer;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_d;
  logic            ovf_run, ovf_run_d;
  logic            last_tick;

  // Two-flop synchronizer plus one edge-detect register; all cleared so a
  // high osc_in after reset must travel the full chain before it counts.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= osc_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_det  = sync2 & ~sync_prev;
  assign last_tick = (timer == LAST_TICK);

  // Saturating edge counter; an edge arriving at full scale marks overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    edge_cnt_d = edge_cnt;
    ovf_run_d  = ovf_run;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) ovf_run_d  = 1'b1;
      else                     edge_cnt_d = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start)     state_d = GATE;
      GATE:    if (last_tick) state_d = DONE;
      DONE:    if (ack)       state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  assign busy  = (state == GATE);
  assign valid = (state == DONE);

`ifdef RING_OSC_METER_STUCK_DETECT_EN
  logic stuck_q;
  assign stuck = stuck_q;
`endif

  // Result registers capture the final-cycle counter value (including an
  // edge seen in that cycle) on the same clock that state enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      edge_cnt <= '0;
      ovf_run  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef RING_OSC_METER_STUCK_DETECT_EN
      stuck_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            timer    <= '0;
            edge_cnt <= '0;
            ovf_run  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef RING_OSC_METER_STUCK_DETECT_EN
            stuck_q  <= 1'b0;
`endif
          end
        end
        GATE: begin
          timer    <= timer + 1'b1;
          edge_cnt <= edge_cnt_d;
          ovf_run  <= ovf_run_d;
          if (last_tick) begin
            count    <= edge_cnt_d;
            overflow <= ovf_run_d;
`ifdef RING_OSC_METER_STUCK_DETECT_EN
            stuck_q  <= (edge_cnt_d < CNT_W'(2));
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: nominal count, idle input, saturation,
// start/ack filtering, result hold and asynchronous reset mid-window.
module tb_ring_osc_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc0, osc1;
  logic en0 = 1'b0, en1 = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic busy0, valid0, overflow0, busy1, valid1, overflow1;
  logic [15:0] count0;
  logic [3:0]  count1;
`ifdef RING_OSC_METER_STUCK_DETECT_EN
  logic stuck0, stuck1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ring_osc_meter #(.GATE_CYCLES(1000), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .osc_in(osc0), .start(start0), .busy(busy0),
    .valid(valid0), .ack(ack0),
`ifdef RING_OSC_METER_STUCK_DETECT_EN
    .stuck(stuck0),
`endif
    .count(count0), .overflow(overflow0));

  ring_osc_meter #(.GATE_CYCLES(100), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .osc_in(osc1), .start(start1), .busy(busy1),
    .valid(valid1), .ack(ack1),
`ifdef RING_OSC_METER_STUCK_DETECT_EN
    .stuck(stuck1),
`endif
    .count(count1), .overflow(overflow1));

  // Oscillator stand-ins: period 10 clk for u0, period 4 clk for u1.
  initial begin
    int c = 0;
    osc0 = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      osc0 = en0 && ((c % 10) < 5);
    end
  end

  initial begin
    int c = 0;
    osc1 = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      osc1 = en1 && ((c % 4) < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [15:0] held;
    logic seen;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_count", count0, 0);
    check("rst_ovf", overflow0, 0);
    rst = 1'b0;
    tick();

    // Nominal window with a stray start in GATE
    en0 = 1'b1;
    repeat (20) tick();
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("gate_busy", busy0, 1);
    n = 0;
    while (busy0 === 1'b1 && n < 1100) begin
      if (n == 300) start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n++;
    end
    check("gate_len", n, 1000);
    check("done_valid", valid0, 1);
    check("done_busy", busy0, 0);
    check("count_100pm1", (count0 >= 99 && count0 <= 101), 1);
    check("nom_ovf", overflow0, 0);
`ifdef RING_OSC_METER_STUCK_DETECT_EN
    check("nom_stuck", stuck0, 0);
`endif

    // DONE hold with start pulsed and ack low for 50 cycles
    held = count0;
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (49) tick();
    check("hold_valid", valid0, 1);
    check("hold_busy", busy0, 0);
    check("hold_count", count0, held);
    start0 = 1'b1; ack0 = 1'b1; tick(); start0 = 1'b0; ack0 = 1'b0;
    check("ack_valid", valid0, 0);
    check("ack_start_ign", busy0, 0);
    repeat (5) tick();
    check("idle_busy", busy0, 0);
    check("idle_count", count0, held);

    // Idle oscillator; ack during GATE is ignored
    en0 = 1'b0;
    repeat (10) tick();
    start0 = 1'b1; tick(); start0 = 1'b0;
    check("start_clr_count", count0, 0);
    n = 0;
    while (busy0 === 1'b1 && n < 1100) begin
      if (n == 100) ack0 = 1'b1;
      tick();
      ack0 = 1'b0;
      n++;
    end
    check("zero_len", n, 1000);
    check("zero_valid", valid0, 1);
    check("zero_count", count0, 0);
    check("zero_ovf", overflow0, 0);
`ifdef RING_OSC_METER_STUCK_DETECT_EN
    check("zero_stuck", stuck0, 1);
`endif
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    check("zero_ack", valid0, 0);

    // Saturation on the narrow instance, then start clears overflow
    en1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n = 0;
    while (valid1 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("sat_len", n, 100);
    check("sat_count", count1, 15);
    check("sat_ovf", overflow1, 1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("sat_idle_ovf", overflow1, 1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("restart_ovf", overflow1, 0);
    check("restart_count", count1, 0);

    // Reset mid-window discards the measurement
    en0 = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (500) tick();
    check("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy0, 0);
    check("arst_valid", valid0, 0);
    check("arst_count", count0, 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (1100) begin
      tick();
      if (valid0 === 1'b1 || busy0 === 1'b1) seen = 1'b1;
    end
    check("no_valid_after_rst", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
